// File: rtl/ov5642_dvp_capture.sv
// OV5642 DVP capture: oversamples the camera bus in the system clock domain,
// pairs bytes into RGB565 pixels with x/y coordinates and frame markers, and
// flags framing violations without ever stalling capture.
`timescale 1ns/1ps
module ov5642_dvp_capture #(
    parameter int H_ACTIVE    = 1280,
    parameter int V_ACTIVE    = 720,
    parameter int SYNC_STAGES = 2,
    parameter bit VSYNC_POL   = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_init_done,
    input  logic        i_cam_pclk,
    input  logic        i_cam_vsync,
    input  logic        i_cam_href,
    input  logic [7:0]  i_cam_data,
    output logic [15:0] o_pix_data,
    output logic        o_pix_valid,
    output logic [11:0] o_pix_x,
    output logic [11:0] o_pix_y,
    output logic        o_sof,
    output logic        o_eol,
    output logic        o_eof,
    output logic        o_frame_err,
    output logic [7:0]  o_err_cnt
);

    localparam logic [11:0] X_MAX = 12'(H_ACTIVE);
    localparam logic [11:0] Y_MAX = 12'(V_ACTIVE);

    typedef enum logic [1:0] {IDLE, WAIT_VS, ACTIVE} state_t;

    logic [SYNC_STAGES-1:0] r_pclk_sync;
    logic [SYNC_STAGES-1:0] r_vsync_sync;
    logic [SYNC_STAGES-1:0] r_href_sync;
    logic [7:0]             r_data_sync [SYNC_STAGES];
    logic                   r_pclk_d;
    logic                   r_href_d;
    logic                   r_vs_blank_d;

    state_t      r_state;
    logic [11:0] r_x;
    logic [11:0] r_y;
    logic        r_phase;
    logic [7:0]  r_hi_byte;
    logic        r_line_drop;
    logic        r_x_flag;
    logic        r_y_flag;
    logic [15:0] r_pix_data;
    logic        r_pix_valid;
    logic [11:0] r_pix_x;
    logic [11:0] r_pix_y;
    logic        r_sof;
    logic        r_eol;
    logic        r_eof;
    logic        r_frame_err;
    logic [7:0]  r_err_cnt;

    logic       w_pclk_rise;
    logic       w_href;
    logic       w_href_rise;
    logic       w_href_fall;
    logic       w_vs_blank;
    logic       w_vs_enter;
    logic       w_vs_leave;
    logic [7:0] w_data;
    logic       w_active;
    logic       w_phase;
    logic       w_drop_line;
    logic       w_byte;
    logic       w_pair;
    logic       w_pix_ok;
    logic       w_err_x;
    logic       w_err_y;
    logic       w_err_odd;
    logic       w_err_short;
    logic       w_err_vs;
    logic       w_err;

    // All camera inputs share one synchroniser depth so PCLK, HREF, VSYNC and
    // DATA stay aligned; VSYNC resets to the non-blanking level so a reset
    // release can never fake an end-of-blanking edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pclk_sync  <= '0;
            r_vsync_sync <= {SYNC_STAGES{~VSYNC_POL}};
            r_href_sync  <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) r_data_sync[i] <= '0;
            r_pclk_d     <= 1'b0;
            r_href_d     <= 1'b0;
            r_vs_blank_d <= 1'b0;
        end else begin
            r_pclk_sync    <= {r_pclk_sync[SYNC_STAGES-2:0], i_cam_pclk};
            r_vsync_sync   <= {r_vsync_sync[SYNC_STAGES-2:0], i_cam_vsync};
            r_href_sync    <= {r_href_sync[SYNC_STAGES-2:0], i_cam_href};
            r_data_sync[0] <= i_cam_data;
            for (int i = 1; i < SYNC_STAGES; i++) r_data_sync[i] <= r_data_sync[i-1];
            r_pclk_d       <= w_pclk_rise | r_pclk_sync[SYNC_STAGES-1];
            r_href_d       <= w_href;
            r_vs_blank_d   <= w_vs_blank;
        end
    end

    // Edge events and violation decode; a VSYNC blanking entry wins over any
    // line event in the same cycle, since the frame is being closed anyway.
    always_comb begin
        w_pclk_rise = r_pclk_sync[SYNC_STAGES-1] & ~r_pclk_d;
        w_href      = r_href_sync[SYNC_STAGES-1];
        w_href_rise = w_href & ~r_href_d;
        w_href_fall = ~w_href & r_href_d;
        w_vs_blank  = (r_vsync_sync[SYNC_STAGES-1] == VSYNC_POL);
        w_vs_enter  = w_vs_blank & ~r_vs_blank_d;
        w_vs_leave  = ~w_vs_blank & r_vs_blank_d;
        w_data      = r_data_sync[SYNC_STAGES-1];
        w_active    = (r_state == ACTIVE) && i_init_done;
        w_phase     = w_href_rise ? 1'b0 : r_phase;
        w_drop_line = w_href_rise ? (r_y == Y_MAX) : r_line_drop;
        w_byte      = w_active && !w_vs_enter && w_pclk_rise && w_href && !w_drop_line;
        w_pair      = w_byte && w_phase;
        w_pix_ok    = w_pair && (r_x != X_MAX);
        w_err_x     = w_pair && (r_x == X_MAX) && !r_x_flag;
        w_err_y     = w_active && !w_vs_enter && w_href_rise && (r_y == Y_MAX) && !r_y_flag;
        w_err_odd   = w_active && !w_vs_enter && w_href_fall && r_phase;
        w_err_short = w_active && !w_vs_enter && w_href_fall && !r_line_drop && (r_x != X_MAX);
        w_err_vs    = w_active && w_vs_enter && ((r_y != Y_MAX) || w_href);
        w_err       = w_err_x | w_err_y | w_err_odd | w_err_short | w_err_vs;
    end

    // Capture state machine with registered pixel, marker and error outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_phase     <= 1'b0;
            r_hi_byte   <= '0;
            r_line_drop <= 1'b0;
            r_x_flag    <= 1'b0;
            r_y_flag    <= 1'b0;
            r_pix_data  <= '0;
            r_pix_valid <= 1'b0;
            r_pix_x     <= '0;
            r_pix_y     <= '0;
            r_sof       <= 1'b0;
            r_eol       <= 1'b0;
            r_eof       <= 1'b0;
            r_frame_err <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_pix_valid <= 1'b0;
            r_sof       <= 1'b0;
            r_eol       <= 1'b0;
            r_eof       <= 1'b0;
            r_frame_err <= w_err;
            if (w_err && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;

            if (!i_init_done) begin
                r_state     <= IDLE;
                r_x         <= '0;
                r_y         <= '0;
                r_phase     <= 1'b0;
                r_line_drop <= 1'b0;
                r_x_flag    <= 1'b0;
                r_y_flag    <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: r_state <= WAIT_VS;
                    WAIT_VS: if (w_vs_leave) r_state <= ACTIVE;
                    ACTIVE: begin
                        if (w_vs_enter) begin
                            r_state     <= WAIT_VS;
                            r_x         <= '0;
                            r_y         <= '0;
                            r_phase     <= 1'b0;
                            r_line_drop <= 1'b0;
                            r_x_flag    <= 1'b0;
                            r_y_flag    <= 1'b0;
                        end else begin
                            if (w_href_rise) begin
                                r_phase     <= 1'b0;
                                r_line_drop <= (r_y == Y_MAX);
                                if (w_err_y) r_y_flag <= 1'b1;
                            end
                            if (w_byte) begin
                                if (!w_phase) begin
                                    r_hi_byte <= w_data;
                                    r_phase   <= 1'b1;
                                end else begin
                                    r_phase <= 1'b0;
                                    if (w_err_x) r_x_flag <= 1'b1;
                                    if (w_pix_ok) begin
                                        r_pix_data  <= {r_hi_byte, w_data};
                                        r_pix_valid <= 1'b1;
                                        r_pix_x     <= r_x;
                                        r_pix_y     <= r_y;
                                        r_sof       <= (r_x == 12'd0) && (r_y == 12'd0);
                                        r_eol       <= (r_x == X_MAX - 12'd1);
                                        r_eof       <= (r_x == X_MAX - 12'd1) && (r_y == Y_MAX - 12'd1);
                                        r_x         <= r_x + 12'd1;
                                    end
                                end
                            end
                            if (w_href_fall) begin
                                r_phase     <= 1'b0;
                                r_line_drop <= 1'b0;
                                r_x_flag    <= 1'b0;
                                if (r_x != 12'd0) begin
                                    r_y <= r_y + 12'd1;
                                    r_x <= '0;
                                end
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign o_pix_data  = r_pix_data;
    assign o_pix_valid = r_pix_valid;
    assign o_pix_x     = r_pix_x;
    assign o_pix_y     = r_pix_y;
    assign o_sof       = r_sof;
    assign o_eol       = r_eol;
    assign o_eof       = r_eof;
    assign o_frame_err = r_frame_err;
    assign o_err_cnt   = r_err_cnt;

endmodule
